// File: rtl/game_pkg.sv
// Constants and types shared between the button conditioner and the sequence game core.
package game_pkg;

  localparam int NBTN = 4;
  localparam int SYM_W = 2;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCK
  } btn_st_t;

  function automatic int count_ones(input logic [NBTN-1:0] v);
    count_ones = 0;
    for (int i = 0; i < NBTN; i++) begin
      if (v[i]) count_ones = count_ones + 1;
    end
  endfunction

  // Only meaningful when v is one-hot; callers check that first.
  function automatic logic [SYM_W-1:0] onehot_index(input logic [NBTN-1:0] v);
    onehot_index = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (v[i]) onehot_index = SYM_W'(i);
    end
  endfunction

endpackage

// File: rtl/debounce1.sv
// One button: two-flop synchronizer followed by a stable-count debouncer.
module debounce1
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic raw,
  output logic lvl
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // The level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else if (run) begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != lvl) begin
        if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
          lvl <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_cond4.sv
// Conditions four raw player buttons into clean one-hot press pulses for the game core.
module btn_cond4
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBTN-1:0]  raw,
  output logic [NBTN-1:0]  b,
  output logic [SYM_W-1:0] code,
  output logic             valid,
  output logic             multi,
  output logic             held
);

  logic             run;
  logic [NBTN-1:0]  lvl;
  logic [NBTN-1:0]  lvl_d;
  logic [NBTN-1:0]  rise;
  int               n_rise;
  btn_st_t          state;
  btn_st_t          state_next;
  logic [NBTN-1:0]  b_next;
  logic [SYM_W-1:0] code_next;
  logic             valid_next;
  logic             multi_next;

  // Reset release is retimed: nothing else moves until the edge after this flop sets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    debounce1 #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .run  (run),
      .raw  (raw[i]),
      .lvl  (lvl[i])
    );
  end

  assign rise = lvl & ~lvl_d;

  always_comb begin
    state_next = state;
    b_next     = '0;
    code_next  = code;
    valid_next = 1'b0;
    multi_next = 1'b0;
    n_rise     = count_ones(rise);
    case (state)
      IDLE: begin
        if (n_rise == 1) begin
          state_next = HELD;
          if (en) begin
            b_next     = rise;
            code_next  = onehot_index(rise);
            valid_next = 1'b1;
          end
        end else if (n_rise > 1) begin
          state_next = LOCK;
          multi_next = en;
        end
      end
      HELD: begin
        if (n_rise != 0) begin
          state_next = LOCK;
          multi_next = en;
        end else if (lvl == '0) begin
          state_next = IDLE;
        end
      end
      LOCK: begin
        if (lvl == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lvl_d <= '0;
      b     <= '0;
      code  <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      held  <= 1'b0;
    end else if (run) begin
      state <= state_next;
      lvl_d <= lvl;
      b     <= b_next;
      code  <= code_next;
      valid <= valid_next;
      multi <= multi_next;
      held  <= |lvl;
    end
  end

endmodule

// File: tb/tb_btn_cond4.sv
// Directed scoreboard bench for btn_cond4 with DEBOUNCE_CYCLES = 4.
module tb_btn_cond4;

  localparam int D = 4;

  typedef struct {
    logic [3:0] b;
    logic [1:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [3:0] raw = '0;
  logic [3:0] b;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       held;

  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses = 0;
  int   multis = 0;
  int   p0;
  int   m0;
  exp_t sb[$];

  btn_cond4 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .raw  (raw),
    .b    (b),
    .code (code),
    .valid(valid),
    .multi(multi),
    .held (held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) pulses <= pulses + 1;
    if (multi) multis <= multis + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic e);
    @(negedge clk);
    raw = r;
    en  = e;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectPress(input logic [3:0] eb, input logic [1:0] ecode);
    exp_t e;
    e.b    = eb;
    e.code = ecode;
    sb.push_back(e);
  endtask

  task automatic waitPulse(input string tag, input int max_cycles);
    logic found;
    exp_t e;
    found = 1'b0;
    for (int k = 0; k < max_cycles && !found; k++) begin
      @(negedge clk);
      if (valid) found = 1'b1;
    end
    checkOutput({tag, "_seen"}, 32'(found), 32'd1);
    if (found && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_b"}, 32'(b), 32'(e.b));
      checkOutput({tag, "_code"}, 32'(code), 32'(e.code));
    end
  endtask

  initial begin
    exp_t e;
    $display("[TB] start");

    // Reset state
    idle(3);
    checkOutput("reset_outs", 32'({b, code, valid, multi, held}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Clean press of button 2: pulse exactly in the cycle after E6
    p0 = pulses;
    applyStimulus(4'b0100, 1'b1);
    idle(6);
    checkOutput("clean_early", 32'(pulses - p0), 32'd0);
    checkOutput("clean_early_valid", 32'(valid), 32'd0);
    expectPress(4'b0100, 2'd2);
    @(negedge clk);
    checkOutput("clean_valid", 32'(valid), 32'd1);
    e = sb.pop_front();
    checkOutput("clean_b", 32'(b), 32'(e.b));
    checkOutput("clean_code", 32'(code), 32'(e.code));
    checkOutput("clean_held", 32'(held), 32'd1);
    @(negedge clk);
    checkOutput("clean_one_cycle", 32'(valid), 32'd0);
    checkOutput("clean_code_hold", 32'(code), 32'd2);
    idle(12);
    checkOutput("clean_no_repeat", 32'(pulses - p0), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    idle(6);
    checkOutput("release_held_still", 32'(held), 32'd1);
    @(negedge clk);
    checkOutput("release_held_clear", 32'(held), 32'd0);
    idle(3);

    // Bounce on button 0 then settle
    p0 = pulses;
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    idle(8);
    checkOutput("bounce_quiet", 32'(pulses - p0), 32'd0);
    checkOutput("bounce_held", 32'(held), 32'd0);
    applyStimulus(4'b0001, 1'b1);
    expectPress(4'b0001, 2'd0);
    waitPulse("bounce", D + 6);
    applyStimulus(4'b0000, 1'b1);
    idle(10);

    // Second button while one is held
    p0 = pulses;
    applyStimulus(4'b0001, 1'b1);
    expectPress(4'b0001, 2'd0);
    waitPulse("multi_first", D + 6);
    idle(3);
    m0 = multis;
    applyStimulus(4'b1001, 1'b1);
    idle(12);
    checkOutput("multi_pulse", 32'(multis - m0), 32'd1);
    checkOutput("multi_no_b", 32'(pulses - p0), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    idle(12);
    checkOutput("multi_release", 32'(held), 32'd0);
    applyStimulus(4'b1000, 1'b1);
    expectPress(4'b1000, 2'd3);
    waitPulse("after_lock", D + 6);
    applyStimulus(4'b0000, 1'b1);
    idle(12);

    // Two buttons rising together, then more while locked
    p0 = pulses;
    m0 = multis;
    applyStimulus(4'b0110, 1'b1);
    idle(12);
    checkOutput("simul_multi", 32'(multis - m0), 32'd1);
    checkOutput("simul_no_b", 32'(pulses - p0), 32'd0);
    checkOutput("simul_held", 32'(held), 32'd1);
    applyStimulus(4'b0111, 1'b1);
    idle(12);
    checkOutput("lock_no_b", 32'(pulses - p0), 32'd0);
    checkOutput("lock_no_multi", 32'(multis - m0), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    idle(12);

    // Press while disabled is lost
    p0 = pulses;
    applyStimulus(4'b0100, 1'b0);
    idle(12);
    applyStimulus(4'b0100, 1'b1);
    idle(10);
    checkOutput("en_lost", 32'(pulses - p0), 32'd0);
    checkOutput("en_held", 32'(held), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    idle(12);
    applyStimulus(4'b0100, 1'b1);
    expectPress(4'b0100, 2'd2);
    waitPulse("en_repress", D + 6);
    applyStimulus(4'b0000, 1'b1);
    idle(12);

    // Async reset mid-debounce, button still held at release
    applyStimulus(4'b1000, 1'b1);
    expectPress(4'b1000, 2'd3);
    waitPulse("pre_reset", D + 6);
    applyStimulus(4'b0010, 1'b1);
    idle(3);
    checkOutput("pre_reset_code", 32'(code), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_clear", 32'({b, code, valid, multi, held}), 32'd0);
    idle(4);
    p0 = pulses;
    @(negedge clk);
    reset = 1'b1;
    expectPress(4'b0010, 2'd1);
    waitPulse("post_reset", D + 8);
    idle(12);
    checkOutput("post_reset_once", 32'(pulses - p0), 32'd1);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
